nn_layer_engine: RTL and testbench

//  Sequenced single-input, N_HID-neuron hidden-layer evaluator: y = OFS + sum_i WY[i]*f(WX[i]*x).

---
 rtl/nn_pkg.sv | 45 ++++
 rtl/nn_fxp_mul.sv | 38 +++
 rtl/nn_layer_engine.sv | 210 +++++++++++++++++++++
 tb/tb_nn_layer_engine.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and fixed-point helpers for the hidden-layer engine.
// Helpers work on 64-bit signed values; callers truncate to their own width.
package nn_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MX   = 3'd1,
    ACT  = 3'd2,
    MY   = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int unsigned FXP_W = 64;

  function automatic logic signed [FXP_W-1:0] fxp_one(input int unsigned frac);
    return 64'sd1 <<< frac;
  endfunction

  function automatic logic signed [FXP_W-1:0] fxp_half(input int unsigned frac);
    return 64'sd1 <<< (frac - 1);
  endfunction

  // Largest and smallest representable value of a w-bit signed word.
  function automatic logic signed [FXP_W-1:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [FXP_W-1:0] sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Hard sigmoid: v/4 + 0.5 clamped to [0, 1.0]; cannot overflow when WIDTH-FRAC >= 2.
  function automatic logic signed [FXP_W-1:0] hard_sigmoid(input logic signed [FXP_W-1:0] v,
                                                           input int unsigned frac);
    logic signed [FXP_W-1:0] t;
    t = (v >>> 2) + fxp_half(frac);
    if (t < 64'sd0) begin
      t = 64'sd0;
    end else if (t > fxp_one(frac)) begin
      t = fxp_one(frac);
    end
    return t;
  endfunction

endpackage

// File: rtl/nn_fxp_mul.sv
// Combinational fixed-point multiply: full product, arithmetic shift by FRAC, overflow flag.
// With NN_SATURATE_EN defined an overflowing result clamps by the sign of the true product.
module nn_fxp_mul
  import nn_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 22
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] y,
  output logic                    ovf
);

  localparam int unsigned PW = 2 * WIDTH;

  logic signed [PW-1:0]  prod;
  logic signed [PW-1:0]  shifted;
  logic        [PW-WIDTH:0] hi;

  // Bits above the kept word (plus its sign bit) must all match for the result to fit.
  always_comb begin
    prod    = PW'(a) * PW'(b);
    shifted = prod >>> FRAC;
    hi      = shifted[PW-1:WIDTH-1];
    ovf     = !((&hi) || !(|hi));
`ifdef NN_SATURATE_EN
    if (ovf) begin
      y = prod[PW-1] ? WIDTH'(sat_min(WIDTH)) : WIDTH'(sat_max(WIDTH));
    end else begin
      y = shifted[WIDTH-1:0];
    end
`else
    y = shifted[WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/nn_layer_engine.sv
// Sequenced N_HID-neuron hidden layer: y = OFS + sum WY[i]*f(WX[i]*x), one neuron per 3 cycles.
// NN_SATURATE_EN selects saturating instead of wrapping arithmetic on overflow.
module nn_layer_engine
  import nn_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned FRAC  = 22,
  parameter  int unsigned N_HID = 10,
  localparam int unsigned AW    = $clog2(2 * N_HID + 1)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  output logic             cfg_drop
);

  localparam int unsigned   NC       = 2 * N_HID + 1;
  localparam logic [AW-1:0] OFS_ADDR = AW'(2 * N_HID);
  localparam logic [AW-1:0] WY_BASE  = AW'(N_HID);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_HID - 1);

  state_t state;
  state_t state_nx;

  logic signed [WIDTH-1:0] coef [NC];
  logic signed [WIDTH-1:0] x_r;
  logic signed [WIDTH-1:0] p_r;
  logic signed [WIDTH-1:0] a_r;
  logic signed [WIDTH-1:0] acc;
  logic [AW-1:0]           idx;
  logic                    err;

  logic                    shd_v;
  logic [AW-1:0]           shd_addr;
  logic signed [WIDTH-1:0] shd_data;

  logic                    accept_c;
  logic                    cfg_ok_c;
  logic [AW-1:0]           wy_addr_c;
  logic signed [WIDTH-1:0] wx_rd_c;
  logic signed [WIDTH-1:0] wy_rd_c;
  logic signed [WIDTH-1:0] px_c;
  logic signed [WIDTH-1:0] py_c;
  logic                    ovf_x_c;
  logic                    ovf_y_c;
  logic signed [WIDTH-1:0] sum_raw_c;
  logic signed [WIDTH-1:0] sum_c;
  logic                    ovf_add_c;
  logic signed [WIDTH-1:0] act_c;

  logic                    out_valid_d;
  logic [WIDTH-1:0]        out_data_d;
  logic                    out_err_d;

  assign in_ready  = (state == IDLE);
  assign accept_c  = in_ready && in_valid;
  assign cfg_ok_c  = cfg_we && in_ready && (cfg_addr <= OFS_ADDR);
  assign wy_addr_c = WY_BASE + idx;

  // A write landing on the accepting edge is hidden from the running computation by the shadow copy.
  assign wx_rd_c = (shd_v && (shd_addr == idx))       ? shd_data : coef[idx];
  assign wy_rd_c = (shd_v && (shd_addr == wy_addr_c)) ? shd_data : coef[wy_addr_c];

  nn_fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_x (
    .a   (x_r),
    .b   (wx_rd_c),
    .y   (px_c),
    .ovf (ovf_x_c)
  );

  nn_fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_y (
    .a   (a_r),
    .b   (wy_rd_c),
    .y   (py_c),
    .ovf (ovf_y_c)
  );

  assign act_c = WIDTH'(hard_sigmoid(64'(p_r), FRAC));

  // Accumulate with signed-overflow detection.
  always_comb begin
    sum_raw_c = acc + py_c;
    ovf_add_c = (acc[WIDTH-1] == py_c[WIDTH-1]) && (sum_raw_c[WIDTH-1] != acc[WIDTH-1]);
`ifdef NN_SATURATE_EN
    if (ovf_add_c) begin
      sum_c = acc[WIDTH-1] ? WIDTH'(sat_min(WIDTH)) : WIDTH'(sat_max(WIDTH));
    end else begin
      sum_c = sum_raw_c;
    end
`else
    sum_c = sum_raw_c;
`endif
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = MX;
      MX:      state_nx = ACT;
      ACT:     state_nx = MY;
      MY:      state_nx = (idx == LAST_IDX) ? DONE : MX;
      DONE:    if (out_valid && out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Result is captured on the first DONE cycle and held until the handshake.
  always_comb begin
    out_valid_d = 1'b0;
    out_data_d  = out_data;
    out_err_d   = out_err;
    if (state == DONE) begin
      out_valid_d = !(out_valid && out_ready);
      if (!out_valid) begin
        out_data_d = acc;
        out_err_d  = err;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_err   <= out_err_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      x_r      <= '0;
      p_r      <= '0;
      a_r      <= '0;
      acc      <= '0;
      idx      <= '0;
      err      <= 1'b0;
      shd_v    <= 1'b0;
      shd_addr <= '0;
      shd_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            x_r      <= $signed(in_data);
            acc      <= coef[OFS_ADDR];
            idx      <= '0;
            err      <= 1'b0;
            shd_v    <= cfg_ok_c;
            shd_addr <= cfg_addr;
            shd_data <= coef[cfg_addr];
          end
        end
        MX: begin
          p_r <= px_c;
          err <= err | ovf_x_c;
        end
        ACT: begin
          a_r <= act_c;
        end
        MY: begin
          acc <= sum_c;
          err <= err | ovf_y_c | ovf_add_c;
          if (idx != LAST_IDX) begin
            idx <= idx + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Coefficient store and sticky drop flag.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < NC; i++) begin
        coef[i] <= '0;
      end
      cfg_drop <= 1'b0;
    end else begin
      if (cfg_ok_c) begin
        coef[cfg_addr] <= $signed(cfg_data);
      end
      if (cfg_we && !cfg_ok_c) begin
        cfg_drop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nn_layer_engine.sv
// Scoreboard bench for nn_layer_engine at default parameters (1.0 = 0x0040_0000).
// Overflow expectations follow NN_SATURATE_EN.
module tb_nn_layer_engine;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned FRAC  = 22;
  localparam int unsigned N_HID = 10;
  localparam int unsigned AW    = $clog2(2 * N_HID + 1);
  localparam int unsigned LAT   = 3 * N_HID + 1;

  localparam logic [WIDTH-1:0] ONE   = 32'h0040_0000;
  localparam logic [WIDTH-1:0] TWO   = 32'h0080_0000;
  localparam logic [WIDTH-1:0] FOUR  = 32'h0100_0000;
  localparam logic [WIDTH-1:0] QUART = 32'h0010_0000;
  localparam logic [WIDTH-1:0] X5    = 32'h0140_0000;
  localparam logic [WIDTH-1:0] X8    = 32'h0200_0000;
  localparam logic [WIDTH-1:0] XM8   = 32'hFE00_0000;
  localparam logic [WIDTH-1:0] X200  = 32'h3200_0000;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
  } exp_t;

  exp_t sb_q[$];

  logic             CLK       = 1'b0;
  logic             reset     = 1'b1;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data   = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic             cfg_we    = 1'b0;
  logic [AW-1:0]    cfg_addr  = '0;
  logic [WIDTH-1:0] cfg_data  = '0;
  logic             cfg_drop;

  int n_err = 0;
  int n_chk = 0;

  nn_layer_engine #(.WIDTH(WIDTH), .FRAC(FRAC), .N_HID(N_HID)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_drop  (cfg_drop)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge CLK);
    reset = 1'b1;
    repeat (n) @(posedge CLK);
    #1 reset = 1'b0;
  endtask

  task automatic cfg_wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    @(negedge CLK);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(posedge CLK);
    #1 cfg_we = 1'b0;
  endtask

  // All coefficients zero except WX[0], WY[0] and OFS.
  task automatic load(input logic [WIDTH-1:0] wx0, input logic [WIDTH-1:0] wy0,
                      input logic [WIDTH-1:0] ofs);
    for (int i = 0; i < 2 * N_HID + 1; i++) cfg_wr(AW'(i), '0);
    cfg_wr(AW'(0), wx0);
    cfg_wr(AW'(N_HID), wy0);
    cfg_wr(AW'(2 * N_HID), ofs);
  endtask

  // mode 0: plain; 1: cfg write on the accepting edge; 2: cfg write one cycle after accept.
  task automatic run_sample(input string tag, input logic [WIDTH-1:0] x,
                            input logic [WIDTH-1:0] exp_d, input logic exp_e, input int hold,
                            input int mode, input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd);
    int   k;
    int   w;
    int   seen;
    exp_t e;
    w = 0;
    @(negedge CLK);
    while (!in_ready && w < 100) begin
      @(negedge CLK);
      w++;
    end
    check({tag, ":in_ready"}, 64'(in_ready), 64'd1);
    sb_q.push_back('{data: exp_d, err: exp_e});
    in_data  = x;
    in_valid = 1'b1;
    if (mode == 1) begin
      cfg_we   = 1'b1;
      cfg_addr = wa;
      cfg_data = wd;
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    k = 0;
    if (mode == 2) begin
      check({tag, ":busy"}, 64'(in_ready), 64'd0);
      cfg_we   = 1'b1;
      cfg_addr = wa;
      cfg_data = wd;
      @(posedge CLK);
      #1 cfg_we = 1'b0;
      k = 1;
    end
    while (!out_valid && k < int'(LAT) + 20) begin
      @(posedge CLK);
      #1;
      k++;
    end
    check({tag, ":latency"}, 64'(k), 64'(LAT));
    check({tag, ":sb_depth"}, 64'(sb_q.size()), 64'd1);
    e = sb_q.pop_front();
    check({tag, ":data"}, 64'(out_data), 64'(e.data));
    check({tag, ":err"}, 64'(out_err), 64'(e.err));
    for (int c = 0; c < hold; c++) begin
      if (c == 2) in_valid = 1'b1;
      @(posedge CLK);
      #1 in_valid = 1'b0;
      check({tag, ":hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, ":hold_data"}, 64'(out_data), 64'(e.data));
      check({tag, ":hold_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge CLK);
    #1 out_ready = 1'b0;
    check({tag, ":valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, ":idle"}, 64'(in_ready), 64'd1);
    if (hold > 0) begin
      seen = 0;
      repeat (LAT + 5) begin
        @(posedge CLK);
        #1;
        if (out_valid) seen++;
      end
      check({tag, ":pulse_ignored"}, 64'(seen), 64'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    logic [WIDTH-1:0] ovf_exp;

    do_reset(3);
    check("rst:out_valid", 64'(out_valid), 64'd0);
    check("rst:out_data", 64'(out_data), 64'd0);
    check("rst:out_err", 64'(out_err), 64'd0);
    check("rst:cfg_drop", 64'(cfg_drop), 64'd0);
    check("rst:in_ready", 64'(in_ready), 64'd1);

    // f(0)=0.5 on every neuron, only WY[0] non-zero: 0.25 + 0.5
    load('0, ONE, QUART);
    run_sample("t2", X5, 32'h0030_0000, 1'b0, 0, 0, '0, '0);

    // Out-of-range address is dropped and leaves the store untouched
    cfg_wr(AW'(21), 32'h1234_5678);
    check("t6:drop_addr", 64'(cfg_drop), 64'd1);
    run_sample("t6a", X5, 32'h0030_0000, 1'b0, 0, 0, '0, '0);
    do_reset(1);
    check("t6:drop_clear", 64'(cfg_drop), 64'd0);

    // WX0=1, WY0=2: f(8)=1.0 -> 2.0, f(-8)=0 -> 0
    load(ONE, TWO, '0);
    run_sample("t3p", X8, TWO, 1'b0, 0, 0, '0, '0);
    run_sample("t3n", XM8, '0, 1'b0, 0, 0, '0, '0);

    run_sample("t5", X8, TWO, 1'b0, 5, 0, '0, '0);

    // Write during MX is dropped; the following result proves WX[0] kept its value
    run_sample("t6b", X8, TWO, 1'b0, 0, 2, AW'(0), 32'h0000_7777);
    check("t6:drop_busy", 64'(cfg_drop), 64'd1);
    run_sample("t6c", X8, TWO, 1'b0, 0, 0, '0, '0);
    do_reset(1);

    // Same-cycle write of WY[0]=0: this sample sees 2.0, the next one sees 0
    load(ONE, TWO, '0);
    run_sample("same1", X8, TWO, 1'b0, 0, 1, AW'(N_HID), '0);
    check("same:no_drop", 64'(cfg_drop), 64'd0);
    run_sample("same2", X8, '0, 1'b0, 0, 0, '0, '0);

    // 200*4 = 800 exceeds the +/-512 integer range of the X product
`ifdef NN_SATURATE_EN
    ovf_exp = ONE;
`else
    ovf_exp = '0;
`endif
    load(FOUR, ONE, '0);
    run_sample("t4ovf", X200, ovf_exp, 1'b1, 0, 0, '0, '0);
    run_sample("t4clean", ONE, ONE, 1'b0, 0, 0, '0, '0);

    // Reset while in MY of neuron 0 aborts and clears the store
    load(ONE, TWO, '0);
    @(negedge CLK);
    in_data  = X8;
    in_valid = 1'b1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1 reset = 1'b1;
    @(posedge CLK);
    #1 reset = 1'b0;
    check("abort:in_ready", 64'(in_ready), 64'd1);
    check("abort:out_valid", 64'(out_valid), 64'd0);
    seen = 0;
    repeat (LAT + 10) begin
      @(posedge CLK);
      #1;
      if (out_valid) seen++;
    end
    check("abort:no_result", 64'(seen), 64'd0);
    run_sample("abort_post", X8, '0, 1'b0, 0, 0, '0, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
